// File: rtl/fpumul_result_queue.sv
// fpumul_result_queue: in-order result FIFO between the FP multiplier and
// writeback. Retires results over valid/ready, accumulates sticky exception
// flags, and turns a trapping head entry into a precise trap with flush.
// Optional build macro FPUMUL_RESQ_PERF_EN adds retire/trap counters; when it
// is undefined the perf ports are tied to zero.
module fpumul_result_queue #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned TAG_W = 9,
  parameter int unsigned SLACK = 2
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       in_en,
  input  logic [TAG_W-1:0]           in_tag,
  input  logic [67:0]                in_res,
  input  logic [15:0]                in_res_hi,
  input  logic [10:0]                in_raise,
  input  logic [10:0]                trap_mask,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [67:0]                out_res,
  output logic [15:0]                out_res_hi,
  output logic [TAG_W-1:0]           out_tag,
  output logic [10:0]                out_raise,
  output logic                       stall,
  output logic [$clog2(DEPTH):0]     count,
  output logic [10:0]                flags_sticky,
  input  logic                       clr_sticky,
  output logic                       trap,
  output logic [TAG_W-1:0]           trap_tag,
  input  logic                       trap_ack,
  output logic                       ovf,
  output logic [31:0]                perf_retired,
  output logic [31:0]                perf_traps
);

  localparam int unsigned AW       = $clog2(DEPTH);
  localparam int unsigned CW       = AW + 1;
  localparam int unsigned STALL_TH = DEPTH - SLACK;

  typedef struct packed {
    logic [TAG_W-1:0] tag;
    logic [67:0]      res;
    logic [15:0]      res_hi;
    logic [10:0]      raise;
    logic             trp;
  } entry_t;

  typedef enum logic {S_IDLE = 1'b0, S_TRAP = 1'b1} state_t;

  entry_t          r_mem [DEPTH];
  entry_t          r_head;
  logic [AW-1:0]   r_wr_ptr;
  logic [AW-1:0]   r_rd_ptr;
  logic [CW-1:0]   r_count;
  state_t          r_state;
  logic            r_out_valid;
  logic            r_trap;
  logic [TAG_W-1:0] r_trap_tag;
  logic [10:0]     r_flags;
  logic            r_ovf;

  entry_t          w_in_entry;
  entry_t          w_head_next;
  logic            w_idle;
  logic            w_full;
  logic            w_pop;
  logic            w_push;
  logic            w_drop;
  logic            w_ack;
  logic            w_to_trap;
  logic [CW-1:0]   w_count_next;
  logic [AW-1:0]   w_rd_next;
  logic [AW-1:0]   w_wr_next;
  state_t          w_state_next;
  logic [10:0]     w_flags_base;

  // Handshake qualification and next-state computation for pointers, FSM and head.
  always_comb begin
    w_in_entry        = '0;
    w_in_entry.tag    = in_tag;
    w_in_entry.res    = in_res;
    w_in_entry.res_hi = in_res_hi;
    w_in_entry.raise  = in_raise;
    w_in_entry.trp    = |(in_raise & trap_mask);

    w_idle    = (r_state == S_IDLE);
    w_full    = (r_count == CW'(DEPTH));
    w_pop     = r_out_valid & out_ready;
    w_push    = in_en & w_idle & (~w_full | w_pop);
    w_drop    = in_en & w_idle & w_full & ~w_pop;
    w_ack     = (r_state == S_TRAP) & trap_ack;
    w_to_trap = w_idle & (r_count != '0) & r_head.trp;

    w_flags_base = clr_sticky ? 11'h000 : r_flags;

    w_count_next = r_count;
    w_rd_next    = r_rd_ptr;
    w_wr_next    = r_wr_ptr;
    w_state_next = r_state;
    if (w_ack) begin
      w_count_next = '0;
      w_rd_next    = '0;
      w_wr_next    = '0;
      w_state_next = S_IDLE;
    end else begin
      w_count_next = r_count + CW'(w_push) - CW'(w_pop);
      if (w_pop)     w_rd_next    = r_rd_ptr + AW'(1);
      if (w_push)    w_wr_next    = r_wr_ptr + AW'(1);
      if (w_to_trap) w_state_next = S_TRAP;
    end

    // Head register tracks the oldest entry; it holds its value once empty.
    w_head_next = r_head;
    if (!w_ack && (w_count_next != '0)) begin
      if (w_push && (w_rd_next == r_wr_ptr)) w_head_next = w_in_entry;
      else                                   w_head_next = r_mem[w_rd_next];
    end
  end

  // Entry storage; written only on an accepted push.
  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr] <= w_in_entry;
  end

  // Queue control, FSM and registered outputs.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_wr_ptr    <= '0;
      r_rd_ptr    <= '0;
      r_count     <= '0;
      r_state     <= S_IDLE;
      r_head      <= '0;
      r_out_valid <= 1'b0;
      r_trap      <= 1'b0;
      r_trap_tag  <= '0;
      r_flags     <= '0;
      r_ovf       <= 1'b0;
    end else begin
      r_wr_ptr    <= w_wr_next;
      r_rd_ptr    <= w_rd_next;
      r_count     <= w_count_next;
      r_state     <= w_state_next;
      r_head      <= w_head_next;
      r_out_valid <= (w_count_next != '0) & (w_state_next == S_IDLE) & ~w_head_next.trp;
      r_trap      <= (w_state_next == S_TRAP);
      if (w_to_trap) r_trap_tag <= r_head.tag;
      if (w_pop || w_ack) r_flags <= w_flags_base | r_head.raise;
      else if (clr_sticky) r_flags <= 11'h000;
      if (w_drop) r_ovf <= 1'b1;
    end
  end

`ifdef FPUMUL_RESQ_PERF_EN
  logic [31:0] r_perf_retired;
  logic [31:0] r_perf_traps;

  // Retirement and trap event counters, free-running with wrap.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_perf_retired <= '0;
      r_perf_traps   <= '0;
    end else begin
      if (w_pop) r_perf_retired <= r_perf_retired + 32'd1;
      if (w_ack) r_perf_traps   <= r_perf_traps + 32'd1;
    end
  end

  assign perf_retired = r_perf_retired;
  assign perf_traps   = r_perf_traps;
`else
  assign perf_retired = 32'd0;
  assign perf_traps   = 32'd0;
`endif

  assign out_valid    = r_out_valid;
  assign out_res      = r_head.res;
  assign out_res_hi   = r_head.res_hi;
  assign out_tag      = r_head.tag;
  assign out_raise    = r_head.raise;
  assign count        = r_count;
  assign flags_sticky = r_flags;
  assign trap         = r_trap;
  assign trap_tag     = r_trap_tag;
  assign ovf          = r_ovf;
  assign stall        = (r_count >= CW'(STALL_TH)) | (r_state != S_IDLE);

endmodule

// File: tb/tb_fpumul_result_queue.sv
// Testbench for fpumul_result_queue: directed scenarios followed by random
// traffic, all checked against a queue-based reference model.
module tb_fpumul_result_queue;

  localparam int unsigned DEPTH = 4;
  localparam int unsigned TAG_W = 9;
  localparam int unsigned SLACK = 2;

  logic              clk = 1'b0;
  logic              rst;
  logic              in_en;
  logic [TAG_W-1:0]  in_tag;
  logic [67:0]       in_res;
  logic [15:0]       in_res_hi;
  logic [10:0]       in_raise;
  logic [10:0]       trap_mask;
  logic              out_valid;
  logic              out_ready;
  logic [67:0]       out_res;
  logic [15:0]       out_res_hi;
  logic [TAG_W-1:0]  out_tag;
  logic [10:0]       out_raise;
  logic              stall;
  logic [2:0]        count;
  logic [10:0]       flags_sticky;
  logic              clr_sticky;
  logic              trap;
  logic [TAG_W-1:0]  trap_tag;
  logic              trap_ack;
  logic              ovf;
  logic [31:0]       perf_retired;
  logic [31:0]       perf_traps;

  fpumul_result_queue #(.DEPTH(DEPTH), .TAG_W(TAG_W), .SLACK(SLACK)) dut (
    .clk(clk), .rst(rst), .in_en(in_en), .in_tag(in_tag), .in_res(in_res),
    .in_res_hi(in_res_hi), .in_raise(in_raise), .trap_mask(trap_mask),
    .out_valid(out_valid), .out_ready(out_ready), .out_res(out_res),
    .out_res_hi(out_res_hi), .out_tag(out_tag), .out_raise(out_raise),
    .stall(stall), .count(count), .flags_sticky(flags_sticky),
    .clr_sticky(clr_sticky), .trap(trap), .trap_tag(trap_tag),
    .trap_ack(trap_ack), .ovf(ovf), .perf_retired(perf_retired),
    .perf_traps(perf_traps)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [TAG_W-1:0] tag;
    logic [67:0]      res;
    logic [15:0]      hi;
    logic [10:0]      raise;
    logic             trp;
  } ent_t;

  // Reference model state
  ent_t        m_q[$];
  ent_t        m_last;
  logic        m_trap;
  logic [TAG_W-1:0] m_trap_tag;
  logic [10:0] m_flags;
  logic        m_ovf;
  int unsigned m_retired;
  int unsigned m_traps;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic exp_out_valid();
    return (m_q.size() != 0) && !m_trap && !m_q[0].trp;
  endfunction

  // Advance the model by one clock using the currently driven inputs.
  task automatic model_next();
    logic pop;
    logic go_trap;
    ent_t e;
    if (!rst) begin
      m_q.delete();
      m_last = '{default: '0};
      m_trap = 1'b0; m_trap_tag = '0; m_flags = '0; m_ovf = 1'b0;
      m_retired = 0; m_traps = 0;
      return;
    end
    pop = exp_out_valid() && out_ready;
    if (m_trap) begin
      if (trap_ack) begin
        m_flags = (clr_sticky ? 11'h000 : m_flags) | m_q[0].raise;
        m_q.delete();
        m_trap = 1'b0;
        m_traps++;
      end else if (clr_sticky) m_flags = 11'h000;
    end else begin
      go_trap = (m_q.size() != 0) && m_q[0].trp;
      if (go_trap) m_trap_tag = m_q[0].tag;
      if (pop) begin
        m_flags = (clr_sticky ? 11'h000 : m_flags) | m_q[0].raise;
        void'(m_q.pop_front());
        m_retired++;
      end else if (clr_sticky) m_flags = 11'h000;
      if (in_en) begin
        if (m_q.size() < DEPTH) begin
          e.tag = in_tag; e.res = in_res; e.hi = in_res_hi; e.raise = in_raise;
          e.trp = |(in_raise & trap_mask);
          m_q.push_back(e);
        end else m_ovf = 1'b1;
      end
      m_trap = go_trap;
    end
    if (m_q.size() != 0) m_last = m_q[0];
  endtask

  task automatic compare_all();
    check("count", count, m_q.size());
    check("out_valid", out_valid, exp_out_valid());
    check("stall", stall, (m_q.size() >= DEPTH - SLACK) || m_trap);
    check("trap", trap, m_trap);
    if (m_trap) check("trap_tag", trap_tag, m_trap_tag);
    check("ovf", ovf, m_ovf);
    check("flags", flags_sticky, m_flags);
    check("out_tag", out_tag, m_last.tag);
    check("out_res", out_res, m_last.res);
    check("out_res_hi", out_res_hi, m_last.hi);
    check("out_raise", out_raise, m_last.raise);
`ifdef FPUMUL_RESQ_PERF_EN
    check("perf_retired", perf_retired, m_retired);
    check("perf_traps", perf_traps, m_traps);
`else
    check("perf_retired_tie", perf_retired, 0);
    check("perf_traps_tie", perf_traps, 0);
`endif
  endtask

  task automatic step();
    model_next();
    @(posedge clk);
    #1;
    compare_all();
  endtask

  task automatic idle_inputs();
    in_en = 1'b0; out_ready = 1'b0; clr_sticky = 1'b0; trap_ack = 1'b0;
    in_raise = '0;
  endtask

  task automatic set_push(input int tag, input logic [10:0] raise);
    in_en = 1'b1; in_tag = TAG_W'(tag); in_raise = raise;
    in_res = {4'($urandom), $urandom, $urandom};
    in_res_hi = 16'($urandom);
  endtask

  task automatic do_reset();
    idle_inputs();
    rst = 1'b0;
    step();
    rst = 1'b1;
  endtask

  initial begin
    rst = 1'b0; trap_mask = '0; in_tag = '0; in_res = '0; in_res_hi = '0;
    idle_inputs();
    do_reset();

    // Single push retires one cycle later
    set_push(5, 11'h000); out_ready = 1'b1;
    step();
    check("first_valid", out_valid, 1'b1);
    check("first_tag", out_tag, 9'd5);
    in_en = 1'b0;
    step();
    check("first_drain", count, 3'd0);

    // Fill to full, overflow, then push+pop at full
    out_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      set_push(10 + i, 11'h000);
      step();
    end
    check("full_ovf", ovf, 1'b1);
    check("full_count", count, 3'd4);
    set_push(20, 11'h000); out_ready = 1'b1;
    step();
    check("full_pushpop", count, 3'd4);
    in_en = 1'b0;
    for (int i = 0; i < 5; i++) step();
    do_reset();

    // Pop with clr_sticky keeps the popped raise bits
    trap_mask = 11'h000;
    set_push(7, 11'h010); out_ready = 1'b0;
    step();
    in_en = 1'b0; out_ready = 1'b1; clr_sticky = 1'b1;
    step();
    check("clr_pop_flags", flags_sticky, 11'h010);
    idle_inputs();
    step();

    // Precise trap on tag 2, tag 3 flushed, pushes ignored while trapping
    trap_mask = 11'h001; out_ready = 1'b1;
    set_push(1, 11'h000); step();
    set_push(2, 11'h001); step();
    set_push(3, 11'h000); step();
    in_en = 1'b0;
    for (int i = 0; i < 8 && !trap; i++) step();
    check("trap_seen", trap, 1'b1);
    check("trap_tag2", trap_tag, 9'd2);
    set_push(40, 11'h000);
    step(); step();
    check("trap_ovf", ovf, 1'b0);
    in_en = 1'b0; trap_ack = 1'b1;
    step();
    check("ack_count", count, 3'd0);
    check("ack_flag0", flags_sticky[0], 1'b1);
    trap_ack = 1'b0;
    step();

    // Reset with entries and a pending trap
    out_ready = 1'b0;
    set_push(50, 11'h001); step();
    set_push(51, 11'h000); step();
    set_push(52, 11'h000); step();
    in_en = 1'b0; step();
    check("pend_trap", trap, 1'b1);
    do_reset();
    check("rst_count", count, 3'd0);
    check("rst_trap", trap, 1'b0);

    // Random traffic
    for (int c = 0; c < 3000; c++) begin
      in_en      = ($urandom_range(0, 99) < 60);
      in_tag     = TAG_W'($urandom);
      in_res     = {4'($urandom), $urandom, $urandom};
      in_res_hi  = 16'($urandom);
      in_raise   = ($urandom_range(0, 3) == 0) ? 11'($urandom) : 11'h000;
      if ($urandom_range(0, 199) == 0) trap_mask = 11'($urandom) & 11'h0f0;
      out_ready  = ($urandom_range(0, 99) < 55);
      clr_sticky = ($urandom_range(0, 19) == 0);
      trap_ack   = ($urandom_range(0, 3) == 0);
      rst        = ($urandom_range(0, 499) != 0);
      step();
    end
    rst = 1'b1;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
